// File: rtl/alu_seq_if.sv
// Handshaked operation/result bus between decode and the sequential ALU.
// The master drives operations and accepts results; the slave is the ALU.
interface alu_seq_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       opcode;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] alu_out;
  logic             a_is_zero;
  logic             zero_flag;
  logic             carry_flag;

  modport master (
    output in_valid, opcode, in_a, in_b, out_ready,
    input  in_ready, out_valid, alu_out, a_is_zero, zero_flag, carry_flag
  );

  modport slave (
    input  in_valid, opcode, in_a, in_b, out_ready,
    output in_ready, out_valid, alu_out, a_is_zero, zero_flag, carry_flag
  );
endinterface

// File: rtl/alu_seq.sv
// Registered ALU with valid/ready flow control. Single-cycle ops complete on
// the accept edge; MUL runs a WIDTH-step shift-add sequence before reporting.
module alu_seq #(
  parameter int WIDTH = 8
) (
  input logic     clk,
  input logic     rst,
  alu_seq_if.slave bus
);
  localparam int SHW = $clog2(WIDTH);
  localparam logic [3:0] OP_MUL = 4'd12;

  typedef enum logic {ST_IDLE, ST_MUL} state_t;

  state_t             state, state_nxt;
  logic [SHW-1:0]     cnt;
  logic [2*WIDTH-1:0] mcand, prod, prod_nxt;
  logic [WIDTH-1:0]   mplier;
  logic               mul_az;

  logic             accept, mul_last;
  logic [SHW-1:0]   sh;
  logic [WIDTH:0]   shl_full;
  logic [WIDTH-1:0] res;
  logic             res_c;

  assign bus.in_ready = (state == ST_IDLE) && (!bus.out_valid || bus.out_ready);
  assign accept       = bus.in_valid && bus.in_ready;
  assign mul_last     = (cnt == SHW'(WIDTH - 1));
  assign prod_nxt     = prod + (mplier[0] ? mcand : '0);
  assign sh           = bus.in_b[SHW-1:0];
  assign shl_full     = {1'b0, bus.in_a} << sh;

  // Single-cycle datapath; MUL never takes this path.
  always_comb begin
    res   = bus.in_a;
    res_c = 1'b0;
    case (bus.opcode)
      4'd2:  {res_c, res} = {1'b0, bus.in_a} + {1'b0, bus.in_b};
      4'd3:  res = bus.in_a & bus.in_b;
      4'd4:  res = bus.in_a ^ bus.in_b;
      4'd5:  res = bus.in_b;
      4'd8:  begin
               res   = bus.in_a - bus.in_b;
               res_c = bus.in_a < bus.in_b;
             end
      4'd9:  res = bus.in_a | bus.in_b;
      4'd10: begin
               res   = shl_full[WIDTH-1:0];
               res_c = shl_full[WIDTH];
             end
      4'd11: res = bus.in_a >> sh;
      default: res = bus.in_a;
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (accept && bus.opcode == OP_MUL) state_nxt = ST_MUL;
      ST_MUL:  if (mul_last) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt            <= '0;
      mcand          <= '0;
      mplier         <= '0;
      prod           <= '0;
      mul_az         <= 1'b0;
      bus.out_valid  <= 1'b0;
      bus.alu_out    <= '0;
      bus.zero_flag  <= 1'b0;
      bus.carry_flag <= 1'b0;
      bus.a_is_zero  <= 1'b0;
    end else if (state == ST_MUL) begin
      prod   <= prod_nxt;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + 1'b1;
      if (mul_last) begin
        bus.alu_out    <= prod_nxt[WIDTH-1:0];
        bus.carry_flag <= |prod_nxt[2*WIDTH-1:WIDTH];
        bus.zero_flag  <= (prod_nxt[WIDTH-1:0] == '0);
        bus.a_is_zero  <= mul_az;
        bus.out_valid  <= 1'b1;
        cnt            <= '0;
      end
    end else if (accept) begin
      if (bus.opcode == OP_MUL) begin
        mcand         <= {{WIDTH{1'b0}}, bus.in_a};
        mplier        <= bus.in_b;
        prod          <= '0;
        cnt           <= '0;
        mul_az        <= (bus.in_a == '0);
        bus.out_valid <= 1'b0;
      end else begin
        bus.alu_out    <= res;
        bus.carry_flag <= res_c;
        bus.zero_flag  <= (res == '0);
        bus.a_is_zero  <= (bus.in_a == '0);
        bus.out_valid  <= 1'b1;
      end
    end else if (bus.out_valid && bus.out_ready) begin
      bus.out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: directed cases plus random traffic against
// a cycle-level behavioural model of the handshake and arithmetic.
module tb_alu_seq;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  alu_seq_if #(.WIDTH(W)) bus();
  alu_seq #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_vec = 0;
  int n_err = 0;

  bit         m_ov;
  int         m_busy;
  logic [W-1:0] m_res, p_res;
  bit         m_c, m_z, m_az, p_c, p_az;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void ref_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                 output logic [W-1:0] r, output bit c);
    int unsigned ua, ub, sh, t;
    ua = a; ub = b; sh = ub % W; c = 0; r = a;
    case (op)
      4'd2:  begin t = ua + ub; r = W'(t); c = (t >= (1 << W)); end
      4'd3:  r = a & b;
      4'd4:  r = a ^ b;
      4'd5:  r = b;
      4'd8:  begin t = ua - ub; r = W'(t); c = (ua < ub); end
      4'd9:  r = a | b;
      4'd10: begin t = ua << sh; r = W'(t); c = ((t >> W) & 1) != 0; end
      4'd11: r = W'(ua >> sh);
      4'd12: begin t = ua * ub; r = W'(t); c = (t >> W) != 0; end
      default: r = a;
    endcase
  endfunction

  // One clock: check what is visible now, drive this cycle's inputs, advance model.
  task automatic cyc(input bit iv, input logic [3:0] op, input logic [W-1:0] a,
                     input logic [W-1:0] b, input bit ordy);
    bit exp_rdy;
    logic [W-1:0] r;
    bit c;
    @(negedge clk);
    bus.in_valid = iv; bus.opcode = op; bus.in_a = a; bus.in_b = b; bus.out_ready = ordy;
    #1;
    exp_rdy = (m_busy == 0) && (!m_ov || ordy);
    chk("in_ready", bus.in_ready, exp_rdy);
    chk("out_valid", bus.out_valid, m_ov);
    if (m_ov) begin
      chk("alu_out", bus.alu_out, m_res);
      chk("carry_flag", bus.carry_flag, m_c);
      chk("zero_flag", bus.zero_flag, m_z);
      chk("a_is_zero", bus.a_is_zero, m_az);
    end
    if (m_busy > 0) begin
      m_busy--;
      if (m_busy == 0) begin
        m_ov = 1; m_res = p_res; m_c = p_c; m_z = (p_res == 0); m_az = p_az;
      end
    end else if (iv && exp_rdy) begin
      ref_op(op, a, b, r, c);
      if (op == 4'd12) begin
        m_busy = W; m_ov = 0; p_res = r; p_c = c; p_az = (a == 0);
      end else begin
        m_ov = 1; m_res = r; m_c = c; m_z = (r == 0); m_az = (a == 0);
      end
    end else if (m_ov && ordy) begin
      m_ov = 0;
    end
  endtask

  task automatic idle(input int n, input bit ordy);
    for (int i = 0; i < n; i++) cyc(1'b0, 4'd0, '0, '0, ordy);
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    rst = 1'b1; bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    #1;
    chk("rst out_valid", bus.out_valid, 0);
    chk("rst alu_out", bus.alu_out, 0);
    chk("rst zero_flag", bus.zero_flag, 0);
    chk("rst carry_flag", bus.carry_flag, 0);
    chk("rst a_is_zero", bus.a_is_zero, 0);
    chk("rst in_ready", bus.in_ready, 1);
    repeat (n) @(negedge clk);
    rst = 1'b0;
    m_ov = 0; m_busy = 0;
  endtask

  initial begin
    bus.in_valid = 1'b0; bus.opcode = '0; bus.in_a = '0; bus.in_b = '0; bus.out_ready = 1'b1;
    m_ov = 0; m_busy = 0;
    do_reset(2);

    // ADD with carry-out
    cyc(1, 4'd2, 8'hF0, 8'h20, 1);
    idle(1, 1);
    // Back-to-back SUBs: equal, then borrow
    cyc(1, 4'd8, 8'h05, 8'h05, 1);
    cyc(1, 4'd8, 8'h03, 8'h05, 1);
    idle(1, 1);
    // MUL with requests offered while busy; they must be ignored
    cyc(1, 4'd12, 8'h0C, 8'h0B, 1);
    for (int i = 0; i < W; i++) cyc(1, 4'd2, 8'h11, 8'h22, 1);
    cyc(1, 4'd12, 8'h20, 8'h10, 1);
    idle(W + 1, 1);
    // Backpressure with XOR pending
    cyc(1, 4'd2, 8'h12, 8'h34, 0);
    for (int i = 0; i < 3; i++) cyc(1, 4'd4, 8'hAA, 8'hFF, 0);
    cyc(1, 4'd4, 8'hAA, 8'hFF, 1);
    idle(1, 1);
    // Shifts and a_is_zero
    cyc(1, 4'd10, 8'h81, 8'h01, 1);
    cyc(1, 4'd11, 8'h81, 8'h09, 1);
    cyc(1, 4'd14, 8'h00, 8'h5A, 1);
    cyc(1, 4'd10, 8'h81, 8'h00, 1);
    idle(1, 1);
    // Reset three cycles into a MUL; its result must never appear
    cyc(1, 4'd12, 8'hFF, 8'hFF, 1);
    idle(3, 1);
    do_reset(1);
    idle(W + 2, 1);
    cyc(1, 4'd2, 8'h01, 8'h02, 1);
    idle(1, 1);

    for (int i = 0; i < 3000; i++) begin
      logic [3:0] op;
      op = ($urandom_range(0, 4) == 0) ? 4'd12 : 4'($urandom_range(0, 15));
      cyc($urandom_range(0, 3) != 0, op, 8'($urandom), 8'($urandom), $urandom_range(0, 3) != 0);
      if (i % 700 == 699) do_reset(1);
    end
    idle(W + 2, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
